ir_fetch_sequencer: RTL and testbench

Sequencer that fills the 16-bit instruction register from byte-wide memory. It reads the low byte at PC and the high byte at PC+1 over a request/acknowledge memory handshake, and drives the IR's byte-load controls (LH, enable, select). It also drives the PC's enable/select to post-increment PC after each byte. It sits between the ARF PC output, the memory port and the IR, and is the producer side of the IR's byte-load interface.

---
 rtl/ir_fetch_sequencer_pkg.sv | 28 ++
 rtl/ir_fetch_sequencer_wait_timer.sv | 32 +++
 rtl/ir_fetch_sequencer.sv | 176 +++++++++++++++++
 tb/tb_ir_fetch_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-register fetch sequencer.
package ir_fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReqLo,
    StLoadLo,
    StReqHi,
    StLoadHi,
    StDone,
    StFault
  } fetch_state_e;

  // Register function selects shared by the IR and PC.
  localparam logic [1:0] SEL_CLEAR = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_DEC   = 2'b10;
  localparam logic [1:0] SEL_INC   = 2'b11;

  // IR byte lane select.
  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

  function automatic logic is_req_state(input fetch_state_e s);
    return (s == StReqLo) || (s == StReqHi);
  endfunction

endpackage

// File: rtl/ir_fetch_sequencer_wait_timer.sv
// Per-byte request wait counter; flags the last allowed request cycle.
module fetch_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clock,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expire
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_count;
  logic            w_expire;

  assign w_expire = (r_count == LastCnt);
  assign o_expire = w_expire;

  // Count unacknowledged request cycles; hold at the last value so it never wraps.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en && !w_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/ir_fetch_sequencer.sv
// Fetches a 16-bit instruction as two bytes (low at PC, high at PC+1) into the IR,
// post-incrementing PC after each byte.
module ir_fetch_sequencer
  import ir_fetch_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] pc_value,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [7:0] ir_data,
  output logic       ir_enable,
  output logic [1:0] ir_select,
  output logic       ir_lh,
  output logic       pc_enable,
  output logic [1:0] pc_select,
  output logic       busy,
  output logic       instr_valid,
  output logic       fault
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic       w_in_req;
  logic       w_expire;
  logic       w_capture;

  logic       w_mem_req;
  logic       w_ir_enable;
  logic [1:0] w_ir_select;
  logic       w_ir_lh;
  logic       w_pc_enable;
  logic [1:0] w_pc_select;
  logic       w_busy;
  logic       w_instr_valid;
  logic       w_fault;

  logic       r_mem_req;
  logic [7:0] r_ir_data;
  logic       r_ir_enable;
  logic [1:0] r_ir_select;
  logic       r_ir_lh;
  logic       r_pc_enable;
  logic [1:0] r_pc_select;
  logic       r_busy;
  logic       r_instr_valid;
  logic       r_fault;

  assign w_in_req  = is_req_state(r_state);
  // Abort wins over an ack arriving in the same cycle.
  assign w_capture = w_in_req && mem_ack && !abort;

  // Timer is held clear outside request states, so it starts at zero on each entry.
  fetch_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock      (clock),
    .rst_n      (rst_n),
    .i_clear    (!w_in_req),
    .i_count_en (w_in_req && !mem_ack),
    .o_expire   (w_expire)
  );

  // Next state, then the output values that state will present once registered.
  always_comb begin
    w_state_next  = r_state;
    w_mem_req     = 1'b0;
    w_ir_enable   = 1'b0;
    w_ir_select   = SEL_CLEAR;
    w_ir_lh       = LH_LOW;
    w_pc_enable   = 1'b0;
    w_pc_select   = SEL_CLEAR;
    w_instr_valid = 1'b0;
    w_fault       = 1'b0;

    if (abort) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle:   if (start) w_state_next = StReqLo;
        StReqLo: begin
          if (mem_ack)       w_state_next = StLoadLo;
          else if (w_expire) w_state_next = StFault;
        end
        StLoadLo: w_state_next = StReqHi;
        StReqHi: begin
          if (mem_ack)       w_state_next = StLoadHi;
          else if (w_expire) w_state_next = StFault;
        end
        StLoadHi: w_state_next = StDone;
        StDone:   w_state_next = StIdle;
        StFault:  w_state_next = StIdle;
        default:  w_state_next = StIdle;
      endcase
    end

    case (w_state_next)
      StReqLo, StReqHi: w_mem_req = 1'b1;
      StLoadLo, StLoadHi: begin
        w_ir_enable = 1'b1;
        w_ir_select = SEL_LOAD;
        w_ir_lh     = (w_state_next == StLoadHi) ? LH_HIGH : LH_LOW;
        w_pc_enable = 1'b1;
        w_pc_select = SEL_INC;
      end
      StDone:  w_instr_valid = 1'b1;
      StFault: w_fault = 1'b1;
      default: ;
    endcase

    w_busy = (w_state_next != StIdle);
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Registered outputs, aligned with the state they describe.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req     <= 1'b0;
      r_ir_enable   <= 1'b0;
      r_ir_select   <= SEL_CLEAR;
      r_ir_lh       <= LH_LOW;
      r_pc_enable   <= 1'b0;
      r_pc_select   <= SEL_CLEAR;
      r_busy        <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_mem_req     <= w_mem_req;
      r_ir_enable   <= w_ir_enable;
      r_ir_select   <= w_ir_select;
      r_ir_lh       <= w_ir_lh;
      r_pc_enable   <= w_pc_enable;
      r_pc_select   <= w_pc_select;
      r_busy        <= w_busy;
      r_instr_valid <= w_instr_valid;
      r_fault       <= w_fault;
    end
  end

  // Capture the acknowledged byte; it is presented to the IR during the following LOAD.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_data <= 8'h00;
    end else if (w_capture) begin
      r_ir_data <= mem_rdata;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_req ? pc_value : 8'h00;
  assign ir_data     = r_ir_data;
  assign ir_enable   = r_ir_enable;
  assign ir_select   = r_ir_select;
  assign ir_lh       = r_ir_lh;
  assign pc_enable   = r_pc_enable;
  assign pc_select   = r_pc_select;
  assign busy        = r_busy;
  assign instr_valid = r_instr_valid;
  assign fault       = r_fault;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Bench for ir_fetch_sequencer: byte memory with scripted ack delays, PC and IR models
// driven by the strobes, and a per-fetch outcome predictor.
module tb_ir_fetch_sequencer;
  import ir_fetch_sequencer_pkg::*;

  localparam int unsigned T = 4;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pc_m  = 8'h00;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ack = 1'b0;
  logic [7:0] ir_data;
  logic       ir_enable;
  logic [1:0] ir_select;
  logic       ir_lh;
  logic       pc_enable;
  logic [1:0] pc_select;
  logic       busy;
  logic       instr_valid;
  logic       fault;

  ir_fetch_sequencer #(
    .TIMEOUT (T)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .pc_value    (pc_m),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .ir_data     (ir_data),
    .ir_enable   (ir_enable),
    .ir_select   (ir_select),
    .ir_lh       (ir_lh),
    .pc_enable   (pc_enable),
    .pc_select   (pc_select),
    .busy        (busy),
    .instr_valid (instr_valid),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  mem [256];
  logic [15:0] ir_m = 16'h0000;
  int          waits_q[$];
  int          cur_cnt = 0;
  int          cyc = 0;
  int          str_ir = 0;
  int          str_pc = 0;
  int          n_req = 0;
  bit          pend_pc = 1'b0;
  bit          pend_ir = 1'b0;
  bit          pend_lh = 1'b0;
  logic [7:0]  pend_data = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({mem_req, mem_addr, ir_data, ir_enable, ir_select, ir_lh, pc_enable,
                pc_select, busy, instr_valid, fault});
  endfunction

  // One clock: apply last cycle's strobes to PC/IR at the edge, then sample and
  // play the memory side at the falling edge.
  task automatic step();
    @(posedge clock);
    if (pend_pc) pc_m = pc_m + 8'd1;
    if (pend_ir) begin
      if (pend_lh) ir_m[15:8] = pend_data;
      else         ir_m[7:0]  = pend_data;
    end
    @(negedge clock);
    cyc++;
    pend_pc   = pc_enable && (pc_select == SEL_INC);
    pend_ir   = ir_enable && (ir_select == SEL_LOAD);
    pend_lh   = ir_lh;
    pend_data = ir_data;
    if (pc_enable) str_pc++;
    if (ir_enable) str_ir++;
    if (mem_req) begin
      n_req++;
      check_eq("mem_addr", 32'(mem_addr), 32'(pc_m));
      if (waits_q.size() > 0 && cur_cnt == waits_q[0]) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[pc_m];
        void'(waits_q.pop_front());
        cur_cnt   = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        cur_cnt++;
      end
    end else begin
      check_eq("mem_addr_idle", 32'(mem_addr), 32'h0);
      // Stray acks outside request states must be ignored.
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      if (cur_cnt > 0) begin
        if (waits_q.size() > 0) void'(waits_q.pop_front());
        cur_cnt = 0;
      end
    end
  endtask

  task automatic arm(input logic [7:0] pc0, input int wlo, input int whi);
    pc_m = pc0;
    waits_q.delete();
    waits_q.push_back(wlo);
    waits_q.push_back(whi);
    cur_cnt = 0;
    cyc     = 0;
    str_ir  = 0;
    str_pc  = 0;
    n_req   = 0;
  endtask

  // One fetch with wlo/whi non-ack cycles before each byte's ack (>= T means never).
  task automatic run_fetch(input logic [7:0] pc0, input int wlo, input int whi,
                           input bit hold, input bit poke);
    logic [15:0] ir0;
    logic [15:0] exp_ir;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  pc1;
    int          exp_cyc;
    int          exp_str;
    int          exp_req;
    bit          exp_fault;
    bit          got;
    bit          got_fault;
    int          ev_cyc;
    int          req_at_ev;
    int          k;

    step();
    ir0 = ir_m;
    pc1 = pc0 + 8'd1;
    lo  = mem[pc0];
    hi  = mem[pc1];
    if (wlo >= int'(T)) begin
      exp_fault = 1'b1; exp_cyc = 1 + int'(T); exp_str = 0;
      exp_ir = ir0; exp_req = int'(T);
    end else if (whi >= int'(T)) begin
      exp_fault = 1'b1; exp_cyc = 3 + wlo + int'(T); exp_str = 1;
      exp_ir = {ir0[15:8], lo}; exp_req = wlo + 1 + int'(T);
    end else begin
      exp_fault = 1'b0; exp_cyc = 5 + wlo + whi; exp_str = 2;
      exp_ir = {hi, lo}; exp_req = wlo + whi + 2;
    end

    arm(pc0, wlo, whi);
    start     = 1'b1;
    got       = 1'b0;
    got_fault = 1'b0;
    ev_cyc    = 0;
    req_at_ev = 0;
    while (!got && cyc < 60) begin
      step();
      start = hold || (poke && cyc == 1);
      if (cyc == 1) check_eq("busy_first", 32'(busy), 32'h1);
      if (instr_valid || fault) begin
        got       = 1'b1;
        got_fault = fault;
        ev_cyc    = cyc;
        req_at_ev = n_req;
      end
    end
    check_eq("fetch_ended", 32'(got), 32'h1);
    check_eq("fault_kind", 32'(got_fault), 32'(exp_fault));
    check_eq("end_cycle", 32'(ev_cyc), 32'(exp_cyc));
    check_eq("req_cycles", 32'(req_at_ev), 32'(exp_req));
    check_eq("ir_strobes", 32'(str_ir), 32'(exp_str));
    check_eq("pc_strobes", 32'(str_pc), 32'(exp_str));
    check_eq("pc_after", 32'(pc_m), 32'(pc0 + 8'(exp_str)));
    check_eq("ir_after", 32'(ir_m), 32'(exp_ir));

    step();
    check_eq("idle_after_end", 32'(busy), 32'h0);
    check_eq("end_pulse_single", 32'(instr_valid || fault), 32'h0);
    step();
    if (hold) begin
      check_eq("restart_busy", 32'(busy), 32'h1);
      check_eq("restart_req", 32'(mem_req), 32'h1);
      start = 1'b0;
      k = 0;
      while (busy && k < 60) begin
        step();
        k++;
      end
      check_eq("drain_done", 32'(busy), 32'h0);
    end else begin
      check_eq("no_extra_fetch", 32'(busy), 32'h0);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h34;
    mem[8'h11] = 8'h12;

    #1;
    check_eq("reset_outputs", all_outputs(), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Zero-wait, late acks, boundary wait, timeouts on each byte.
    run_fetch(8'h10, 0, 0, 1'b0, 1'b0);
    check_eq("zw_ir", 32'(ir_m), 32'h1234);
    check_eq("zw_pc", 32'(pc_m), 32'h12);
    run_fetch(8'h10, 3, 3, 1'b0, 1'b0);
    run_fetch(8'h10, 0, int'(T) + 2, 1'b0, 1'b0);
    check_eq("to_ir_lo", 32'(ir_m[7:0]), 32'h34);
    run_fetch(8'h20, int'(T) - 1, int'(T) - 1, 1'b0, 1'b0);
    run_fetch(8'h50, int'(T), 0, 1'b0, 1'b0);

    // Abort together with the high-byte ack.
    step();
    arm(8'h40, 0, 0);
    start = 1'b1;
    k = 0;
    while (!(mem_req && str_pc == 1) && k < 20) begin
      step();
      start = 1'b0;
      k++;
    end
    check_eq("abort_reached_req_hi", 32'(mem_req && str_pc == 1), 32'h1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_idle", 32'(busy), 32'h0);
    check_eq("abort_no_req", 32'(mem_req), 32'h0);
    repeat (3) step();
    check_eq("abort_ir_strobes", 32'(str_ir), 32'h1);
    check_eq("abort_pc", 32'(pc_m), 32'h41);
    check_eq("abort_ir_lo", 32'(ir_m[7:0]), 32'(mem[8'h40]));

    // Asynchronous reset during LOAD_LO.
    step();
    arm(8'h30, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("rst_in_load_lo", 32'(ir_enable), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_outputs", all_outputs(), 32'h0);
    pend_pc = 1'b0;
    pend_ir = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    run_fetch(8'h30, 0, 0, 1'b0, 1'b0);

    // Back-to-back with start held, and a start pulse ignored in REQ_LO.
    run_fetch(8'h60, 0, 0, 1'b1, 1'b0);
    run_fetch(8'h70, 2, 1, 1'b0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      run_fetch(8'($urandom), int'($urandom_range(0, T + 1)), int'($urandom_range(0, T + 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
